// File: rtl/sprite_compositor.sv
// sprite_compositor: overlays one solid rectangular sprite on a solid background, 2-stage ce-gated pipeline
// Ports: clk_rgb/rst_n/ce clock, async reset and pixel enable; x/y/hs/vs/de raster inputs;
//        sprite_x/sprite_y/sprite_color/upd_valid double-buffered sprite update, upd_ack on apply;
//        bg_color live background; frame_start on vs onset; rgb/hs_out/vs_out/de_out delayed by 2 ce cycles.
module sprite_compositor #(
  parameter int X_WIDTH           = 10,
  parameter int Y_WIDTH           = 10,
  parameter int SPRITE_W          = 16,
  parameter int SPRITE_H          = 16,
  parameter int COLOR_WIDTH       = 24,
  parameter bit VER_SYNC_POLARITY = 1'b0,
  parameter bit HOR_SYNC_POLARITY = 1'b0
) (
  input  logic                   clk_rgb,
  input  logic                   rst_n,
  input  logic                   ce,
  input  logic [X_WIDTH-1:0]     x,
  input  logic [Y_WIDTH-1:0]     y,
  input  logic                   hs,
  input  logic                   vs,
  input  logic                   de,
  input  logic [X_WIDTH-1:0]     sprite_x,
  input  logic [Y_WIDTH-1:0]     sprite_y,
  input  logic [COLOR_WIDTH-1:0] sprite_color,
  input  logic [COLOR_WIDTH-1:0] bg_color,
  input  logic                   upd_valid,
  output logic                   upd_ack,
  output logic                   frame_start,
  output logic [COLOR_WIDTH-1:0] rgb,
  output logic                   hs_out,
  output logic                   vs_out,
  output logic                   de_out
);
  localparam logic [X_WIDTH:0] SW = (X_WIDTH+1)'(SPRITE_W);
  localparam logic [Y_WIDTH:0] SH = (Y_WIDTH+1)'(SPRITE_H);
  logic [X_WIDTH-1:0]     r_act_x, r_pend_x;
  logic [Y_WIDTH-1:0]     r_act_y, r_pend_y;
  logic [COLOR_WIDTH-1:0] r_act_c, r_pend_c;
  logic                   r_pend, r_vs_prev;
  logic                   r_hit_x, r_hit_y, r_hs, r_vs, r_de;
  logic                   w_onset, w_apply, w_hit_x, w_hit_y;
  assign w_onset = ce && (vs == VER_SYNC_POLARITY) && (r_vs_prev != VER_SYNC_POLARITY);
  assign w_apply = w_onset && (upd_valid || r_pend);
  // one extra bit so the right/bottom edge never wraps back to column/row 0
  assign w_hit_x = ({1'b0, x} >= {1'b0, r_act_x}) && ({1'b0, x} < {1'b0, r_act_x} + SW);
  assign w_hit_y = ({1'b0, y} >= {1'b0, r_act_y}) && ({1'b0, y} < {1'b0, r_act_y} + SH);
  always_ff @(posedge clk_rgb or negedge rst_n)
    if (!rst_n) begin
      r_act_x     <= '0;
      r_act_y     <= '0;
      r_act_c     <= '0;
      r_pend_x    <= '0;
      r_pend_y    <= '0;
      r_pend_c    <= '0;
      r_pend      <= 1'b0;
      r_vs_prev   <= ~VER_SYNC_POLARITY;
      r_hit_x     <= 1'b0;
      r_hit_y     <= 1'b0;
      r_hs        <= ~HOR_SYNC_POLARITY;
      r_vs        <= ~VER_SYNC_POLARITY;
      r_de        <= 1'b0;
      rgb         <= '0;
      hs_out      <= ~HOR_SYNC_POLARITY;
      vs_out      <= ~VER_SYNC_POLARITY;
      de_out      <= 1'b0;
      upd_ack     <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= w_onset;
      upd_ack     <= w_apply;
      // an update arriving on the onset cycle itself goes straight to the active set
      if (w_apply) begin
        r_act_x <= upd_valid ? sprite_x : r_pend_x;
        r_act_y <= upd_valid ? sprite_y : r_pend_y;
        r_act_c <= upd_valid ? sprite_color : r_pend_c;
        r_pend  <= 1'b0;
      end else if (upd_valid) begin
        r_pend_x <= sprite_x;
        r_pend_y <= sprite_y;
        r_pend_c <= sprite_color;
        r_pend   <= 1'b1;
      end
      if (ce) begin
        r_vs_prev <= vs;
        r_hit_x   <= w_hit_x;
        r_hit_y   <= w_hit_y;
        r_hs      <= hs;
        r_vs      <= vs;
        r_de      <= de;
        rgb       <= !r_de ? '0 : (r_hit_x && r_hit_y) ? r_act_c : bg_color;
        hs_out    <= r_hs;
        vs_out    <= r_vs;
        de_out    <= r_de;
      end
    end
endmodule

// File: tb/tb_sprite_compositor.sv
// tb_sprite_compositor: randomized and directed checks of sprite_compositor against a behavioural model
module tb_sprite_compositor;
  localparam logic [23:0] RED = 24'hFF0000, BLUE = 24'h0000FF, GREEN = 24'h00FF00;
  logic        clk_rgb = 1'b0, rst_n = 1'b0, ce = 1'b0;
  logic [9:0]  x = '0, y = '0, sprite_x = '0;
  logic [9:0]  sprite_y = '0;
  logic        hs = 1'b1, vs = 1'b1, de = 1'b0, upd_valid = 1'b0;
  logic [23:0] sprite_color = '0, bg_color = '0;
  logic        upd_ack, frame_start, hs_out, vs_out, de_out;
  logic [23:0] rgb;
  int checks = 0, errors = 0;
  int m_x, m_y, m_px, m_py;
  logic [23:0] m_c, m_pc, e_rgb;
  bit m_pend, m_vs_prev, s_hit, s_hs, s_vs, s_de, e_hs, e_vs, e_de, e_ack, e_fs;
  logic [23:0] got [64];
  sprite_compositor dut (
    .clk_rgb(clk_rgb), .rst_n(rst_n), .ce(ce), .x(x), .y(y), .hs(hs), .vs(vs), .de(de),
    .sprite_x(sprite_x), .sprite_y(sprite_y), .sprite_color(sprite_color), .bg_color(bg_color),
    .upd_valid(upd_valid), .upd_ack(upd_ack), .frame_start(frame_start), .rgb(rgb),
    .hs_out(hs_out), .vs_out(vs_out), .de_out(de_out)
  );
  always #5 clk_rgb = ~clk_rgb;
  task automatic model_reset();
    m_x = 0; m_y = 0; m_px = 0; m_py = 0; m_c = '0; m_pc = '0; m_pend = 0; m_vs_prev = 1;
    s_hit = 0; s_hs = 1; s_vs = 1; s_de = 0;
    e_rgb = '0; e_hs = 1; e_vs = 1; e_de = 0; e_ack = 0; e_fs = 0;
  endtask
  // sprite is a rectangle [m_x, m_x+16) x [m_y, m_y+16) in unbounded integer space
  task automatic model_edge();
    bit onset;
    onset = ce && !vs && m_vs_prev;
    e_fs = onset;
    e_ack = 0;
    if (ce) begin
      e_rgb = !s_de ? 24'h0 : s_hit ? m_c : bg_color;
      e_hs = s_hs; e_vs = s_vs; e_de = s_de;
      s_hit = int'(x) >= m_x && int'(x) < m_x + 16 && int'(y) >= m_y && int'(y) < m_y + 16;
      s_hs = hs; s_vs = vs; s_de = de;
      m_vs_prev = vs;
    end
    if (onset && (upd_valid || m_pend)) begin
      m_x = upd_valid ? int'(sprite_x) : m_px;
      m_y = upd_valid ? int'(sprite_y) : m_py;
      m_c = upd_valid ? sprite_color : m_pc;
      m_pend = 0;
      e_ack = 1;
    end else if (upd_valid) begin
      m_px = int'(sprite_x); m_py = int'(sprite_y); m_pc = sprite_color; m_pend = 1;
    end
  endtask
  task automatic tick();
    @(posedge clk_rgb);
    model_edge();
    @(negedge clk_rgb);
    upd_valid = 1'b0;
  endtask
  task automatic idle(input bit v);
    ce = 1; hs = 1; vs = v; de = 0; x = '0; y = '0;
    tick();
  endtask
  task automatic request(input int sx, input int sy, input logic [23:0] c);
    sprite_x = 10'(sx); sprite_y = 10'(sy); sprite_color = c; upd_valid = 1;
  endtask
  task automatic vsync();
    idle(1); idle(0); idle(0); idle(1);
  endtask
  task automatic sweep(input int yy, input int x0, input int n);
    for (int i = 0; i < n + 2; i++) begin
      ce = 1; hs = 1; vs = 1; de = (i < n); x = 10'(x0 + i); y = 10'(yy);
      tick();
      if (i >= 1) got[i-1] = rgb;
    end
  endtask
  task automatic test_reset();
    checks++;
    if ({rgb, de_out, hs_out, vs_out, upd_ack, frame_start} !== {24'h0, 5'b01100}) begin
      errors++; $display("FAIL reset_state got=%h/%b%b%b%b%b", rgb, de_out, hs_out, vs_out, upd_ack, frame_start);
    end
    for (int i = 0; i < 4; i++) begin
      idle(1);
      checks++;
      if ({rgb, de_out, hs_out, vs_out, upd_ack, frame_start} !== {24'h0, 5'b01100}) begin
        errors++; $display("FAIL reset_idle got=%h/%b%b%b%b%b", rgb, de_out, hs_out, vs_out, upd_ack, frame_start);
      end
    end
  endtask
  task automatic test_sweep();
    bg_color = BLUE;
    request(100, 50, RED); idle(1); vsync();
    sweep(50, 99, 18);
    for (int i = 0; i < 18; i++) begin
      checks++;
      if (got[i] !== ((99 + i >= 100 && 99 + i <= 115) ? RED : BLUE)) begin
        errors++; $display("FAIL sweep_y50 x=%0d got=%h exp=%h", 99 + i, got[i], (99 + i >= 100 && 99 + i <= 115) ? RED : BLUE);
      end
    end
    sweep(49, 99, 18);
    for (int i = 0; i < 18; i++) begin
      checks++;
      if (got[i] !== BLUE) begin errors++; $display("FAIL sweep_y49 x=%0d got=%h exp=%h", 99 + i, got[i], BLUE); end
    end
    sweep(66, 99, 18);
    for (int i = 0; i < 18; i++) begin
      checks++;
      if (got[i] !== BLUE) begin errors++; $display("FAIL sweep_y66 x=%0d got=%h exp=%h", 99 + i, got[i], BLUE); end
    end
  endtask
  task automatic test_update();
    request(200, 10, GREEN);
    sweep(50, 100, 1);
    checks++;
    if (got[0] !== RED || upd_ack !== 1'b0) begin
      errors++; $display("FAIL upd_midframe got=%h ack=%b exp=%h ack=0", got[0], upd_ack, RED);
    end
    idle(1);
    checks++;
    if ({upd_ack, frame_start} !== 2'b00) begin errors++; $display("FAIL upd_pre_onset got=%b exp=00", {upd_ack, frame_start}); end
    idle(0);
    checks++;
    if ({upd_ack, frame_start} !== 2'b11) begin errors++; $display("FAIL upd_onset got=%b exp=11", {upd_ack, frame_start}); end
    idle(0);
    checks++;
    if ({upd_ack, frame_start} !== 2'b00) begin errors++; $display("FAIL upd_after got=%b exp=00", {upd_ack, frame_start}); end
    idle(1);
    sweep(10, 198, 20);
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (got[i] !== ((198 + i >= 200 && 198 + i <= 215) ? GREEN : BLUE)) begin
        errors++; $display("FAIL upd_newpos x=%0d got=%h", 198 + i, got[i]);
      end
    end
  endtask
  task automatic test_back_to_back();
    int acks = 0;
    request(5, 5, GREEN); idle(1); idle(1);
    request(7, 7, RED); idle(1);
    idle(1); idle(0); acks += upd_ack; idle(0); acks += upd_ack; idle(1); acks += upd_ack; idle(1); acks += upd_ack;
    checks++;
    if (acks != 1) begin errors++; $display("FAIL b2b_ack_count got=%0d exp=1", acks); end
    sweep(7, 5, 4);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got[i] !== ((5 + i >= 7) ? RED : BLUE)) begin errors++; $display("FAIL b2b_pos x=%0d got=%h", 5 + i, got[i]); end
    end
    idle(1);
    request(20, 20, GREEN); idle(0);
    checks++;
    if ({upd_ack, frame_start} !== 2'b11) begin errors++; $display("FAIL bypass_ack got=%b exp=11", {upd_ack, frame_start}); end
    idle(1);
    sweep(20, 19, 2);
    checks++;
    if (got[0] !== BLUE || got[1] !== GREEN) begin
      errors++; $display("FAIL bypass_pos got=%h,%h exp=%h,%h", got[0], got[1], BLUE, GREEN);
    end
  endtask
  task automatic test_edge_clip();
    request(1016, 0, RED); vsync();
    sweep(0, 1008, 24);
    for (int i = 0; i < 24; i++) begin
      checks++;
      if (got[i] !== ((i >= 8 && i < 16) ? RED : BLUE)) begin
        errors++; $display("FAIL clip x=%0d got=%h exp=%h", (1008 + i) % 1024, got[i], (i >= 8 && i < 16) ? RED : BLUE);
      end
    end
  endtask
  task automatic test_ce_and_reset();
    bit cs [6] = '{1, 0, 0, 1, 0, 1};
    logic [23:0] ex [6] = '{24'h0, 24'h0, 24'h0, RED, RED, BLUE};
    request(100, 50, RED); vsync();
    idle(1); idle(1);
    for (int i = 0; i < 6; i++) begin
      ce = cs[i]; hs = 1; vs = 1; de = (i == 0 || i == 3); y = 10'd50; x = (i == 0) ? 10'd100 : 10'd0;
      tick();
      checks++;
      if (rgb !== ex[i] || {rgb, hs_out, vs_out, de_out} !== {e_rgb, e_hs, e_vs, e_de}) begin
        errors++; $display("FAIL ce_hold step=%0d got=%h exp=%h model=%h", i, rgb, ex[i], e_rgb);
      end
    end
    request(300, 300, GREEN); sweep(50, 100, 1);
    ce = 1; de = 1; x = 10'd100; y = 10'd50; tick();
    #2 rst_n = 0;
    #1;
    checks++;
    if ({rgb, de_out, hs_out, vs_out, upd_ack, frame_start} !== {24'h0, 5'b01100}) begin
      errors++; $display("FAIL async_reset got=%h/%b%b%b%b%b", rgb, de_out, hs_out, vs_out, upd_ack, frame_start);
    end
    model_reset();
    @(negedge clk_rgb) rst_n = 1;
    idle(1); idle(0);
    checks++;
    if ({upd_ack, frame_start} !== 2'b01) begin errors++; $display("FAIL reset_drops_pending got=%b exp=01", {upd_ack, frame_start}); end
    idle(1);
    sweep(0, 0, 17);
    checks++;
    if (got[0] !== 24'h0 || got[16] !== BLUE) begin
      errors++; $display("FAIL reset_sprite got=%h,%h exp=000000,%h", got[0], got[16], BLUE);
    end
  endtask
  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      ce = ($urandom_range(0, 3) != 0);
      hs = ((i % 50) >= 4);
      vs = ((i % 300) >= 5);
      de = $urandom_range(0, 1);
      x = (i % 7 == 0) ? 10'($urandom) : 10'($urandom_range(0, 80));
      y = 10'($urandom_range(0, 80));
      bg_color = 24'($urandom);
      if ($urandom_range(0, 60) == 0) request($urandom_range(0, 70), $urandom_range(0, 70), 24'($urandom));
      tick();
      checks++;
      if ({rgb, hs_out, vs_out, de_out, upd_ack, frame_start} !== {e_rgb, e_hs, e_vs, e_de, e_ack, e_fs}) begin
        errors++; $display("FAIL random cyc=%0d got=%h/%b%b%b%b%b exp=%h/%b%b%b%b%b", i,
          rgb, hs_out, vs_out, de_out, upd_ack, frame_start, e_rgb, e_hs, e_vs, e_de, e_ack, e_fs);
      end
    end
  endtask
  initial begin
    model_reset();
    repeat (3) @(negedge clk_rgb);
    rst_n = 1;
    test_reset();
    test_sweep();
    test_update();
    test_back_to_back();
    test_edge_clip();
    test_ce_and_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sprite_compositor.md
Name: sprite_compositor

Overview:
- Sits directly downstream of the raster timing generator. Consumes its per-pixel coordinates, sync signals and data-enable.
- Produces registered RGB pixels with matching delayed sync/enable for the video output PHY.
- Composites one rectangular solid-colour sprite over a solid background colour.
- Sprite position/colour updates are double-buffered and applied only at vertical-sync onset, so frames never tear.

Parameters:
- X_WIDTH, 10, width of incoming active-area x coordinate
- Y_WIDTH, 10, width of incoming active-area y coordinate
- SPRITE_W, 16, sprite width in pixels (1..2**X_WIDTH)
- SPRITE_H, 16, sprite height in pixels (1..2**Y_WIDTH)
- COLOR_WIDTH, 24, packed RGB width
- VER_SYNC_POLARITY, 0, active level of vs/vs_out
- HOR_SYNC_POLARITY, 0, active level of hs/hs_out

Ports:
- clk_rgb  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- ce  in  1  pixel-advance enable; pipeline moves only when 1
- x  in  X_WIDTH  active-area x from timing generator
- y  in  Y_WIDTH  active-area y from timing generator
- hs  in  1  horizontal sync from timing generator
- vs  in  1  vertical sync from timing generator
- de  in  1  data enable from timing generator
- sprite_x  in  X_WIDTH  requested sprite left edge
- sprite_y  in  Y_WIDTH  requested sprite top edge
- sprite_color  in  COLOR_WIDTH  requested sprite colour
- bg_color  in  COLOR_WIDTH  background colour, used live (not buffered)
- upd_valid  in  1  single-cycle request to load sprite_x/sprite_y/sprite_color
- upd_ack  out  1  one-cycle pulse when a pending update becomes active
- frame_start  out  1  one-cycle pulse (ce-qualified) on vs onset
- rgb  out  COLOR_WIDTH  output pixel
- hs_out  out  1  hs delayed by pipeline latency
- vs_out  out  1  vs delayed by pipeline latency
- de_out  out  1  de delayed by pipeline latency

Behaviour:
- Reset (rst_n low, async):
  - rgb=0, de_out=0.
  - hs_out=~HOR_SYNC_POLARITY, vs_out=~VER_SYNC_POLARITY.
  - upd_ack=0, frame_start=0.
  - Active sprite regs (pos and colour) = 0; pending regs = 0; pending flag = 0.
  - Previous-vs register = ~VER_SYNC_POLARITY.
  - Reset mid-frame discards any pending update.
- Update capture (every clk_rgb, independent of ce):
  - upd_valid=1 loads the pending regs and sets the pending flag.
  - A second upd_valid before application overwrites the pending regs; latest wins, and only one upd_ack is issued.
- vs onset: the ce cycle where vs==VER_SYNC_POLARITY and previous vs!=VER_SYNC_POLARITY.
  - frame_start pulses in the following cycle.
  - If the pending flag is set, pending regs copy to the active regs, the flag clears, and upd_ack pulses in the following cycle.
  - If upd_valid is asserted in the same cycle as onset, the new values bypass the pending regs and become active at this onset.
- Pipeline: 2 stages, advancing only on ce. Latency is exactly 2 ce cycles for rgb/hs_out/vs_out/de_out relative to x/y/hs/vs/de.
  - Stage 1 registers: hit_x = (x >= sx) && (x < sx+SPRITE_W), and hit_y likewise for y.
    - Comparisons are done in X_WIDTH+1 / Y_WIDTH+1 bits, so sx+SPRITE_W never wraps.
    - A sprite extending past the active area is clipped by de, not wrapped to the opposite edge.
  - Stage 1 also registers hs/vs/de.
  - Stage 2 selects: !de → 0; hit_x&&hit_y → active sprite_color; otherwise bg_color (sampled at stage 2).
- Active regs change only at vs onset, i.e. never during active video, so a frame uses one consistent sprite state.
- ce=0: all pipeline regs, previous-vs register and outputs hold.
  - upd_ack and frame_start are cleared on the next clk_rgb regardless of ce, so each is at most 1 cycle wide.

Test Plan:
1. Reset, then ce=1 with idle inputs (de=0, hs=vs=1, polarity 0) → rgb=0, de_out=0, hs_out=vs_out=1. Upd regs 0; no upd_ack or frame_start.
2. Active sprite at (100,50), colour 0xFF0000, bg 0x0000FF; sweep y=50 with x=99..116, de=1 → after 2 ce cycles: x=99 gives 0x0000FF, x=100..115 give 0xFF0000, x=116 gives 0x0000FF. Repeat at y=49 and y=66 → all 0x0000FF.
3. upd_valid with (200,10) mid-frame → frame unchanged until vs falls; frame_start and upd_ack pulse once in the following cycle; the next frame shows the sprite at (200,10).
4. Two upd_valid pulses in one frame ((5,5) then (7,7)) → single upd_ack; (7,7) active next frame. Also drive upd_valid in the exact vs-onset cycle → applied at that onset.
5. Sprite x = 2**X_WIDTH-8, SPRITE_W=16 → only the last 8 columns are coloured; no wrap to x=0..7.
6. ce toggling 1,0,0,1 during active video → outputs hold while ce=0; latency counted in ce cycles stays 2. Async rst_n pulse mid-line → outputs return to reset values immediately and the pending update is lost.
